// File: rtl/mem_stage_cache.sv
// mem_stage_cache: MEM-stage cache for the ARM pipeline.
// WAYS-way set-associative, write-through, read-allocate, tree pseudo-LRU,
// backed by an external SRAM that returns whole lines on reads and accepts
// single-word writes. Optional macro CACHE_STATS_EN adds saturating read
// hit/miss counters (hit_count, miss_count).
module mem_stage_cache #(
  parameter int          WAYS       = 2,
  parameter int          SETS       = 64,
  parameter int          LINE_WORDS = 2,
  parameter logic [31:0] ADDR_BASE  = 32'd1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_en_in,
  input  logic                     mem_r_en,
  input  logic                     mem_w_en,
  input  logic [31:0]              alu_res,
  input  logic [31:0]              val_rm,
  output logic                     wb_en_out,
  output logic [31:0]              data_mem,
  output logic                     ready,
  output logic                     mem_rd_req,
  output logic                     mem_wr_req,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  input  logic                     mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int LW  = 32 * LINE_WORDS;
  localparam int WB  = $clog2(LINE_WORDS);
  localparam int WSW = (WB > 0) ? WB : 1;
  localparam int IB  = $clog2(SETS);
  localparam int TW  = 30 - WB - IB;
  localparam int WIW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PW  = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Tag/valid/PLRU and data storage
  logic [WAYS-1:0] valid_q [SETS];
  logic [PW-1:0]   plru_q  [SETS];
  logic [TW-1:0]   tag_q   [SETS][WAYS];
  logic [LW-1:0]   data_q  [SETS][WAYS];

  // Address decode
  logic [31:0]    ea;
  logic [WSW-1:0] wsel;
  logic [IB-1:0]  idx;
  logic [TW-1:0]  tag;
  logic [WSW+4:0] wbit;

  // Lookup results and array update controls
  logic [WAYS-1:0] hit_vec;
  logic            hit;
  logic [WIW-1:0]  hit_way;
  logic [WIW-1:0]  fill_way;
  logic            inv_found;
  logic [31:0]     hit_word;
  logic [31:0]     fill_word;
  logic            fill_en;
  logic            wr_hit_en;
  logic            touch_en;
  logic [WIW-1:0]  touch_way;
  logic            rd_hit_evt;
  logic            rd_miss_done;
  logic            unused_ok;

  // Tree PLRU: bit 0 is the root; a 1 points the victim to the upper half.
  // For 4 ways, bit 1 picks within ways 0/1 and bit 2 within ways 2/3.
  function automatic logic [1:0] plru_victim(input logic [2:0] p);
    logic [1:0] v;
    v = 2'd0;
    if (WAYS == 2) begin
      v = {1'b0, p[0]};
    end else if (WAYS == 4) begin
      v = p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
    end
    return v;
  endfunction

  // Point every node on the path away from the way just used.
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] n;
    n = p;
    if (WAYS == 2) begin
      n[0] = ~w[0];
    end else if (WAYS == 4) begin
      n[0] = ~w[1];
      if (w[1]) n[2] = ~w[0];
      else      n[1] = ~w[0];
    end
    return n;
  endfunction

  assign ea        = alu_res - ADDR_BASE;
  assign wsel      = ea[2 +: WSW] & WSW'(LINE_WORDS - 1);
  assign idx       = ea[2 + WB +: IB];
  assign tag       = ea[31 -: TW];
  assign wbit      = {wsel, 5'b0};
  assign mem_addr  = {ea[31:2], 2'b00};
  assign mem_wdata = mem_wr_req ? val_rm : '0;
  assign wb_en_out = wb_en_in & ready;
  assign fill_word = mem_rdata[wbit +: 32];
  assign unused_ok = &{1'b0, ea[1:0], rd_hit_evt, rd_miss_done};

  // Tag compare across the ways of the addressed set
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      if (hit_vec[w]) hit_way = WIW'(w);
    end
    hit      = |hit_vec;
    hit_word = data_q[idx][hit_way][wbit +: 32];
  end

  // Victim selection: lowest invalid way, otherwise the PLRU victim
  always_comb begin
    inv_found = 1'b0;
    fill_way  = WIW'(plru_victim(3'(plru_q[idx])));
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[idx][w]) begin
        fill_way  = WIW'(w);
        inv_found = 1'b1;
      end
    end
  end

  // FSM next state, handshake outputs and array update strobes
  always_comb begin
    state_d      = state_q;
    ready        = 1'b1;
    data_mem     = '0;
    mem_rd_req   = 1'b0;
    mem_wr_req   = 1'b0;
    fill_en      = 1'b0;
    wr_hit_en    = 1'b0;
    touch_en     = 1'b0;
    touch_way    = hit_way;
    rd_hit_evt   = 1'b0;
    rd_miss_done = 1'b0;
    if (!rst) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A simultaneous load and store is handled as the store.
          if (mem_w_en) begin
            ready      = 1'b0;
            mem_wr_req = 1'b1;
            state_d    = WR_THRU;
          end else if (mem_r_en) begin
            if (hit) begin
              data_mem   = hit_word;
              touch_en   = 1'b1;
              rd_hit_evt = 1'b1;
            end else begin
              ready      = 1'b0;
              mem_rd_req = 1'b1;
              state_d    = RD_MISS;
            end
          end
        end
        RD_MISS: begin
          mem_rd_req = 1'b1;
          if (mem_ready) begin
            data_mem     = fill_word;
            fill_en      = 1'b1;
            touch_en     = 1'b1;
            touch_way    = fill_way;
            rd_miss_done = 1'b1;
            state_d      = IDLE;
          end else begin
            ready = 1'b0;
          end
        end
        WR_THRU: begin
          mem_wr_req = 1'b1;
          if (mem_ready) begin
            state_d = IDLE;
            if (hit) begin
              wr_hit_en = 1'b1;
              touch_en  = 1'b1;
            end
          end else begin
            ready = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Valid and PLRU bits, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (fill_en) valid_q[idx][fill_way] <= 1'b1;
      if (touch_en) plru_q[idx] <= PW'(plru_touch(3'(plru_q[idx]), 2'(touch_way)));
    end
  end

  // Tag and data arrays; contents are qualified by valid so no reset needed
  always_ff @(posedge clk) begin
    if (rst) begin
      if (fill_en) begin
        data_q[idx][fill_way] <= mem_rdata;
        tag_q[idx][fill_way]  <= tag;
      end
      if (wr_hit_en) data_q[idx][hit_way][wbit +: 32] <= val_rm;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating read hit/miss counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rd_hit_evt && (hit_cnt_q != '1))    hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (rd_miss_done && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
